// File: rtl/lt24_pattern_gen_pkg.sv
// lt24_pattern_pkg: shared types, RGB565 constants and bar helpers for the
// LT24 test-pattern generator. Optional border feature: LT24_PATTERN_BORDER_EN.
package lt24_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_GRADIENT    = 2'd0,
        MODE_COLOUR_BARS = 2'd1,
        MODE_CHECKER     = 2'd2,
        MODE_SOLID       = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Colour of bar idx, left (0) to right (7).
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

    // First column of bar k; only ever called with constant arguments.
    function automatic int unsigned bar_threshold(input int unsigned width,
                                                  input int unsigned k);
        return (k * width) / 8;
    endfunction

endpackage

// File: rtl/lt24_pattern_gen_if.sv
// Pixel-addressing bus between the pattern generator and the LT24 core.
interface lt24_pattern_gen_if #(
    parameter int unsigned X_BITS = 8,
    parameter int unsigned Y_BITS = 9
);
    logic              pixelWrite;
    logic              pixelReady;
    logic [X_BITS-1:0] xAddr;
    logic [Y_BITS-1:0] yAddr;
    logic [15:0]       pixelData;

    modport master (output pixelWrite, xAddr, yAddr, pixelData, input pixelReady);
    modport slave  (input pixelWrite, xAddr, yAddr, pixelData, output pixelReady);
endinterface

// File: rtl/lt24_pattern_gen_colour.sv
// lt24_pattern_colour: combinational RGB565 colour for one pixel.
// Optional LT24_PATTERN_BORDER_EN forces the frame border to white.
module lt24_pattern_colour
    import lt24_pattern_pkg::*;
#(
    parameter int unsigned WIDTH        = 240,
    parameter int unsigned HEIGHT       = 320,
    parameter int unsigned X_BITS       = 8,
    parameter int unsigned Y_BITS       = 9,
    parameter int unsigned CHECKER_LOG2 = 4
) (
    input  logic [X_BITS-1:0] x_i,
    input  logic [Y_BITS-1:0] y_i,
    input  mode_e             mode_i,
    input  logic [15:0]       solid_i,
    input  logic [4:0]        fc_i,
    output logic [15:0]       pixel_o
);

    logic [2:0] bar_idx;
    logic       y_unused;

    // Some low y bits feed no pattern in every configuration.
    assign y_unused = ^y_i;

    // Pattern select; bar index counts constant thresholds the column has passed.
    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(x_i) >= bar_threshold(WIDTH, k)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end

        case (mode_i)
            MODE_GRADIENT:    pixel_o = {x_i[X_BITS-1 -: 5], y_i[Y_BITS-1 -: 6], fc_i};
            MODE_COLOUR_BARS: pixel_o = bar_colour(bar_idx);
            MODE_CHECKER:     pixel_o = (x_i[CHECKER_LOG2] ^ y_i[CHECKER_LOG2] ^ fc_i[0])
                                        ? RGB_WHITE : RGB_BLACK;
            default:          pixel_o = solid_i;
        endcase

`ifdef LT24_PATTERN_BORDER_EN
        if (x_i == '0 || 32'(x_i) == WIDTH - 1 || y_i == '0 || 32'(y_i) == HEIGHT - 1) begin
            pixel_o = RGB_WHITE;
        end
`endif
    end

endmodule

// File: rtl/lt24_pattern_gen.sv
// lt24_pattern_gen: raster-order test-pattern source for the LT24 display.
// Optional border feature selected by LT24_PATTERN_BORDER_EN.
module lt24_pattern_gen
    import lt24_pattern_pkg::*;
#(
    parameter int unsigned WIDTH        = 240,
    parameter int unsigned HEIGHT       = 320,
    parameter int unsigned X_BITS       = 8,
    parameter int unsigned Y_BITS       = 9,
    parameter int unsigned FRAME_BITS   = 8,
    parameter int unsigned CHECKER_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  resetApp,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [15:0]           solidColour,
    lt24_pattern_gen_if.master    pix,
    output logic                  frameDone,
    output logic [FRAME_BITS-1:0] frameCount
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);

    state_e                state_q, state_d;
    logic [X_BITS-1:0]     x_q, x_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    mode_e                 mode_q, mode_d;
    logic [15:0]           solid_q, solid_d;
    logic [FRAME_BITS-1:0] fc_q, fc_d;
    logic                  write_q, write_d;
    logic                  done_q, done_d;
    logic [15:0]           data_q, data_d;
    logic [15:0]           colour_next;
    logic                  load;

    // Colour is computed from the next-state address so data registers with it.
    lt24_pattern_colour #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .X_BITS       (X_BITS),
        .Y_BITS       (Y_BITS),
        .CHECKER_LOG2 (CHECKER_LOG2)
    ) u_colour (
        .x_i     (x_d),
        .y_i     (y_d),
        .mode_i  (mode_d),
        .solid_i (solid_d),
        .fc_i    (fc_d[4:0]),
        .pixel_o (colour_next)
    );

    // State and output registers; asynchronous reset abandons any frame.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= MODE_GRADIENT;
            solid_q <= '0;
            fc_q    <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            fc_q    <= fc_d;
            write_q <= write_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    // Next-state: raster advance on acceptance, relatch or stop at frame end.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        solid_d = solid_q;
        fc_d    = fc_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = mode_e'(mode);
                    solid_d = solidColour;
                    load    = 1'b1;
                end
            end
            default: begin
                if (write_q && pix.pixelReady) begin
                    load = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d    = '0;
                            done_d = 1'b1;
                            fc_d   = fc_q + 1'b1;
                            if (enable) begin
                                mode_d  = mode_e'(mode);
                                solid_d = solidColour;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
        endcase

        write_d = (state_d == ST_ACTIVE);
        data_d  = load ? colour_next : data_q;
    end

    assign pix.pixelWrite = write_q;
    assign pix.xAddr      = x_q;
    assign pix.yAddr      = y_q;
    assign pix.pixelData  = data_q;
    assign frameDone      = done_q;
    assign frameCount     = fc_q;

endmodule

// File: tb/tb_lt24_pattern_gen.sv
// Directed bench for lt24_pattern_gen. Main instance uses a 240x24 frame to
// keep multi-frame scenarios short; a 16x4 instance exercises frameCount wrap.
module tb_lt24_pattern_gen;

    logic        clock;
    logic        resetApp;
    logic        enable, enable_s;
    logic [1:0]  mode, mode_s;
    logic [15:0] solidColour;
    logic        frameDone, frameDone_s;
    logic [7:0]  frameCount;
    logic [4:0]  frameCount_s;

    int vectors;
    int miscompares;

    lt24_pattern_gen_if #(.X_BITS(8), .Y_BITS(6)) pix ();
    lt24_pattern_gen_if #(.X_BITS(5), .Y_BITS(6)) pix_s ();

    lt24_pattern_gen #(
        .WIDTH(240), .HEIGHT(24), .X_BITS(8), .Y_BITS(6), .FRAME_BITS(8), .CHECKER_LOG2(4)
    ) dut (
        .clock       (clock),
        .resetApp    (resetApp),
        .enable      (enable),
        .mode        (mode),
        .solidColour (solidColour),
        .pix         (pix.master),
        .frameDone   (frameDone),
        .frameCount  (frameCount)
    );

    lt24_pattern_gen #(
        .WIDTH(16), .HEIGHT(4), .X_BITS(5), .Y_BITS(6), .FRAME_BITS(5), .CHECKER_LOG2(4)
    ) dut_s (
        .clock       (clock),
        .resetApp    (resetApp),
        .enable      (enable_s),
        .mode        (mode_s),
        .solidColour (16'h0000),
        .pix         (pix_s.master),
        .frameDone   (frameDone_s),
        .frameCount  (frameCount_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance until the main instance presents (wx,wy); timeout is a miscompare.
    task automatic wait_pix(input int wx, input int wy, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pix.pixelWrite === 1'b1 && int'(pix.xAddr) == wx && int'(pix.yAddr) == wy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_pix(%0d,%0d) timeout got=(%0d,%0d) exp=(%0d,%0d)",
                     wx, wy, pix.xAddr, pix.yAddr, wx, wy);
        end
    endtask

    task automatic test_reset();
        resetApp = 1'b1; enable = 1'b0; mode = 2'd0; solidColour = 16'h0;
        enable_s = 1'b0; mode_s = 2'd0;
        pix.pixelReady = 1'b1; pix_s.pixelReady = 1'b1;
        step();
        vectors++; if (pix.pixelWrite !== 1'b0) begin miscompares++; $display("FAIL rst_write got=%b exp=0", pix.pixelWrite); end
        vectors++; if (pix.xAddr !== 8'd0) begin miscompares++; $display("FAIL rst_x got=%0d exp=0", pix.xAddr); end
        vectors++; if (pix.yAddr !== 6'd0) begin miscompares++; $display("FAIL rst_y got=%0d exp=0", pix.yAddr); end
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL rst_data got=%h exp=0000", pix.pixelData); end
        vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", frameDone); end
        vectors++; if (frameCount !== 8'd0) begin miscompares++; $display("FAIL rst_fc got=%0d exp=0", frameCount); end
        resetApp = 1'b0;
        step();
        vectors++; if (pix.pixelWrite !== 1'b0) begin miscompares++; $display("FAIL idle_write got=%b exp=0", pix.pixelWrite); end
    endtask

    task automatic test_gradient();
        mode = 2'd0; enable = 1'b1;
        step();
        vectors++; if (pix.pixelWrite !== 1'b1 || pix.xAddr !== 8'd0 || pix.yAddr !== 6'd0)
            begin miscompares++; $display("FAIL grad_first got=w%b(%0d,%0d) exp=w1(0,0)", pix.pixelWrite, pix.xAddr, pix.yAddr); end
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL grad_00 got=%h exp=0000", pix.pixelData); end
        wait_pix(8, 1, 400);
        vectors++; if (pix.pixelData !== 16'h0820) begin miscompares++; $display("FAIL grad_8_1 got=%h exp=0820", pix.pixelData); end
        wait_pix(239, 23, 6000);
        vectors++; if (pix.pixelData !== 16'hEAE0) begin miscompares++; $display("FAIL grad_last_f0 got=%h exp=EAE0", pix.pixelData); end
        vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL grad_done_early got=%b exp=0", frameDone); end
        step();
        vectors++; if (frameDone !== 1'b1 || frameCount !== 8'd1) begin miscompares++; $display("FAIL grad_done_f0 got=d%b fc%0d exp=d1 fc1", frameDone, frameCount); end
        vectors++; if (pix.xAddr !== 8'd0 || pix.yAddr !== 6'd0 || pix.pixelData !== 16'h0001)
            begin miscompares++; $display("FAIL grad_f1_00 got=(%0d,%0d)%h exp=(0,0)0001", pix.xAddr, pix.yAddr, pix.pixelData); end
        step();
        vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL grad_done_pulse got=%b exp=0", frameDone); end
        wait_pix(239, 23, 6000);
        vectors++; if (pix.pixelData !== 16'hEAE1) begin miscompares++; $display("FAIL grad_last_f1 got=%h exp=EAE1", pix.pixelData); end
        enable = 1'b0;
        step();
        vectors++; if (frameDone !== 1'b1 || frameCount !== 8'd2 || pix.pixelWrite !== 1'b0)
            begin miscompares++; $display("FAIL grad_stop got=d%b fc%0d w%b exp=d1 fc2 w0", frameDone, frameCount, pix.pixelWrite); end
    endtask

    task automatic test_colour_bars();
        mode = 2'd1; enable = 1'b1;
        step();
        vectors++; if (pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL bars_0 got=%h exp=FFFF", pix.pixelData); end
        wait_pix(29, 0, 300);
        vectors++; if (pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL bars_29 got=%h exp=FFFF", pix.pixelData); end
        step();
        vectors++; if (pix.xAddr !== 8'd30 || pix.pixelData !== 16'hFFE0) begin miscompares++; $display("FAIL bars_30 got=x%0d %h exp=x30 FFE0", pix.xAddr, pix.pixelData); end
        wait_pix(60, 0, 300);
        vectors++; if (pix.pixelData !== 16'h07FF) begin miscompares++; $display("FAIL bars_60 got=%h exp=07FF", pix.pixelData); end
        wait_pix(209, 0, 300);
        vectors++; if (pix.pixelData !== 16'h001F) begin miscompares++; $display("FAIL bars_209 got=%h exp=001F", pix.pixelData); end
        wait_pix(210, 0, 300);
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL bars_210 got=%h exp=0000", pix.pixelData); end
        wait_pix(239, 0, 300);
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL bars_239 got=%h exp=0000", pix.pixelData); end
        mode = 2'd2;
        step();
        vectors++; if (pix.yAddr !== 6'd1 || pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL bars_midmode got=y%0d %h exp=y1 FFFF", pix.yAddr, pix.pixelData); end
    endtask

    task automatic test_checker_and_stall();
        wait_pix(239, 23, 6000);
        step();
        vectors++; if (frameCount !== 8'd3 || pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL chk_f3_00 got=fc%0d %h exp=fc3 FFFF", frameCount, pix.pixelData); end
        wait_pix(10, 0, 50);
        pix.pixelReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (pix.pixelWrite !== 1'b1 || pix.xAddr !== 8'd10 || pix.yAddr !== 6'd0 || pix.pixelData !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL stall_%0d got=w%b(%0d,%0d)%h exp=w1(10,0)FFFF", i, pix.pixelWrite, pix.xAddr, pix.yAddr, pix.pixelData);
            end
        end
        pix.pixelReady = 1'b1;
        step();
        vectors++; if (pix.xAddr !== 8'd11 || pix.yAddr !== 6'd0) begin miscompares++; $display("FAIL stall_release got=(%0d,%0d) exp=(11,0)", pix.xAddr, pix.yAddr); end
        wait_pix(16, 0, 50);
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL chk_f3_16 got=%h exp=0000", pix.pixelData); end
        wait_pix(239, 23, 6000);
        step();
        vectors++; if (frameCount !== 8'd4 || pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL chk_f4_00 got=fc%0d %h exp=fc4 0000", frameCount, pix.pixelData); end
        wait_pix(16, 0, 50);
        vectors++; if (pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL chk_f4_16 got=%h exp=FFFF", pix.pixelData); end
        wait_pix(0, 16, 5000);
        vectors++; if (pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL chk_f4_0_16 got=%h exp=FFFF", pix.pixelData); end
    endtask

    task automatic test_enable_drop();
        wait_pix(100, 16, 300);
        enable = 1'b0; mode = 2'd3; solidColour = 16'h1234;
        wait_pix(120, 16, 50);
        vectors++; if (pix.pixelData !== 16'h0000) begin miscompares++; $display("FAIL drop_120 got=%h exp=0000", pix.pixelData); end
        wait_pix(239, 23, 2000);
        vectors++; if (pix.pixelWrite !== 1'b1 || pix.pixelData !== 16'hFFFF) begin miscompares++; $display("FAIL drop_last got=w%b %h exp=w1 FFFF", pix.pixelWrite, pix.pixelData); end
        step();
        vectors++; if (frameDone !== 1'b1 || frameCount !== 8'd5 || pix.pixelWrite !== 1'b0)
            begin miscompares++; $display("FAIL drop_end got=d%b fc%0d w%b exp=d1 fc5 w0", frameDone, frameCount, pix.pixelWrite); end
        step();
        vectors++; if (frameDone !== 1'b0 || pix.pixelWrite !== 1'b0) begin miscompares++; $display("FAIL drop_idle got=d%b w%b exp=d0 w0", frameDone, pix.pixelWrite); end
        enable = 1'b1;
        step();
        vectors++; if (pix.pixelWrite !== 1'b1 || pix.pixelData !== 16'h1234 || frameCount !== 8'd5)
            begin miscompares++; $display("FAIL solid_00 got=w%b %h fc%0d exp=w1 1234 fc5", pix.pixelWrite, pix.pixelData, frameCount); end
    endtask

    task automatic test_reset_mid_frame();
        wait_pix(5, 0, 20);
        #2 resetApp = 1'b1;
        #1;
        vectors++; if (pix.pixelWrite !== 1'b0 || pix.xAddr !== 8'd0 || pix.pixelData !== 16'h0000 || frameCount !== 8'd0 || frameDone !== 1'b0)
            begin miscompares++; $display("FAIL async_rst got=w%b x%0d %h fc%0d d%b exp=w0 x0 0000 fc0 d0", pix.pixelWrite, pix.xAddr, pix.pixelData, frameCount, frameDone); end
        step();
        vectors++; if (pix.pixelWrite !== 1'b0) begin miscompares++; $display("FAIL rst_held got=%b exp=0", pix.pixelWrite); end
        resetApp = 1'b0;
        step();
        vectors++; if (pix.pixelWrite !== 1'b1 || pix.xAddr !== 8'd0 || pix.yAddr !== 6'd0 || frameCount !== 8'd0 || pix.pixelData !== 16'h1234)
            begin miscompares++; $display("FAIL rst_restart got=w%b(%0d,%0d) fc%0d %h exp=w1(0,0) fc0 1234", pix.pixelWrite, pix.xAddr, pix.yAddr, frameCount, pix.pixelData); end
        enable = 1'b0;
    endtask

    task automatic test_frame_wrap();
        int  pulses;
        bit  seen;
        enable_s = 1'b1; mode_s = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (int'(pix_s.xAddr) == 15 && int'(pix_s.yAddr) == 3) seen = 1'b1;
        end
        vectors++; if (!seen || pix_s.pixelData !== 16'h7860) begin miscompares++; $display("FAIL small_grad got=%h exp=7860 seen=%b", pix_s.pixelData, seen); end
        pulses = 0;
        for (int i = 0; i < 2300 && pulses < 32; i++) begin
            step();
            if (frameDone_s === 1'b1) begin
                pulses++;
                if (pulses == 31) begin
                    vectors++; if (frameCount_s !== 5'd31) begin miscompares++; $display("FAIL wrap_31 got=%0d exp=31", frameCount_s); end
                end
                if (pulses == 32) begin
                    vectors++; if (frameCount_s !== 5'd0) begin miscompares++; $display("FAIL wrap_0 got=%0d exp=0", frameCount_s); end
                end
            end
        end
        vectors++; if (pulses != 32) begin miscompares++; $display("FAIL wrap_pulses got=%0d exp=32", pulses); end
        enable_s = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_gradient();
        test_colour_bars();
        test_checker_and_stall();
        test_enable_drop();
        test_reset_mid_frame();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lt24_pattern_gen.md
# lt24_pattern_gen

Parametrised test-pattern generator that drives the pixel-addressing interface of the LT24 display controller. It produces full frames in one of four selectable patterns, supports display back-pressure through a write/ready handshake, and counts completed frames. It replaces the fixed gradient generator and sits between user control logic (mode and enable) and the display core.

## Interface
- WIDTH, 240: active pixels per line
- HEIGHT, 320: lines per frame
- X_BITS, 8: xAddr width, at least 5 and at least clog2(WIDTH)
- Y_BITS, 9: yAddr width, at least 6 and at least clog2(HEIGHT)
- FRAME_BITS, 8: frame counter width, at least 5
- CHECKER_LOG2, 4: checker square edge is 2^CHECKER_LOG2 pixels

Ports:
- clock  in  1  system clock
- resetApp  in  1  asynchronous, active-high reset
- enable  in  1  run request; level-sensitive
- mode  in  2  0 = GRADIENT, 1 = COLOUR_BARS, 2 = CHECKER, 3 = SOLID
- solidColour  in  16  RGB565 colour for SOLID mode
- pixelReady  in  1  display accepts the presented pixel
- pixelWrite  out  1  pixel presented and valid
- xAddr  out  X_BITS  pixel column
- yAddr  out  Y_BITS  pixel row
- pixelData  out  16  RGB565 pixel colour
- frameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted
- frameCount  out  FRAME_BITS  number of completed frames; wraps to 0

## Operation
- FSM states: IDLE and ACTIVE.
- IDLE: pixelWrite=0. When enable=1, latch mode and solidColour, load pixel (0,0), and go to ACTIVE.
- ACTIVE: pixelWrite=1. A pixel is accepted when pixelWrite and pixelReady are both 1 in the same cycle. On acceptance, the next pixel is presented in raster order (x increments; at x=WIDTH-1, x wraps to 0 and y increments).
- Acceptance of (WIDTH-1, HEIGHT-1):
  - frameDone pulses.
  - frameCount increments, wrapping from 2^FRAME_BITS-1 to 0.
  - If enable=1: relatch mode and solidColour, then present (0,0).
  - Else: go to IDLE.
- A frame is never truncated. Dropping enable mid-frame takes effect only at frame end.
- Changes to mode or solidColour mid-frame are ignored until the next latch point.
- Patterns, computed from the presented x, y and frameCount:
  - GRADIENT: R = x[X_BITS-1 -: 5], G = y[Y_BITS-1 -: 6], B = frameCount[4:0].
  - COLOUR_BARS: bar index = number of k in 1..7 with x ≥ k*WIDTH/8, using elaboration-time constants (no divider). Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - CHECKER: c = x[CHECKER_LOG2] ^ y[CHECKER_LOG2] ^ frameCount[0]. pixelData = FFFF if c, else 0000.
  - SOLID: the latched solidColour.
- Reset, asynchronous, clears all outputs to 0:
  - pixelWrite, xAddr, yAddr, pixelData, frameDone, frameCount are 0.
  - State is IDLE and the latched mode is GRADIENT.
  - Reset mid-frame abandons the frame. The next frame starts at (0,0) with frameCount 0.

## Timing
- All outputs are registered.
- Latency: enable rising in IDLE gives pixelWrite=1 with (0,0) and valid pixelData on the next cycle.
- xAddr, yAddr and pixelData are mutually consistent in every cycle. They are held stable while pixelWrite=1 and pixelReady=0.
- The new pixel appears the cycle after acceptance. Throughput is 1 pixel/clock with pixelReady held high, including across frame boundaries when enable stays 1.
- frameDone is asserted in the cycle after the last-pixel acceptance, coincident with the updated frameCount.

## Configuration
- LT24_PATTERN_BORDER_EN defined: pixels with x=0, x=WIDTH-1, y=0 or y=HEIGHT-1 are forced to FFFF in every mode.
- LT24_PATTERN_BORDER_EN undefined: patterns are unmodified and no border logic is present.

## Structure
- Package lt24_pattern_pkg holds:
  - the mode enum
  - RGB565 colour constants
  - the bar-colour lookup
  - a constant function computing the bar thresholds from WIDTH
- Sub-module lt24_pattern_colour: combinational colour computation from (x, y, latched mode, solidColour, frameCount). The top module keeps the FSM, counters and output registers.

## Test plan
Unless noted, defaults are used, pixelReady is held at 1 and the border macro is undefined.
- GRADIENT, first frame: (0,0) gives 0000; (239,319) gives ECE0; the next frame's (239,319) gives ECE1.
- COLOUR_BARS: x=29 gives FFFF, x=30 gives FFE0, x=210 gives 0000, x=239 gives 0000.
- CHECKER: frame 0 has (0,0)=0000 and (16,0)=FFFF; frame 1 has (0,0)=FFFF.
- pixelReady=0 for 5 cycles while (10,0) is presented: outputs are stable and pixelWrite=1; (11,0) appears the cycle after pixelReady returns to 1.
- enable dropped at (100,50) and mode changed to SOLID mid-frame: the frame completes in the old mode, frameDone pulses once, frameCount=1, and pixelWrite=0 the following cycle.
- resetApp asserted mid-frame: all outputs are 0 immediately; after release with enable=1, (0,0) is presented one cycle later.
